uart_frame_sched: RTL and testbench

- Frame scheduler and ROM-handshake controller for the RS485 UART transmitter.
- Runs on the system clock. Issues the transmit request (RQ) once per frame period and steps the frame index (cycle) that the transmitter uses to address the ROM.
- Answers the transmitter's per-byte ROM requests with a read strobe plus a delayed ack.
- Detects transmitter timeouts and frame-period overruns.

---
 rtl/uart_frame_sched.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// -----------------------------------------------------------------------------
// uart_frame_sched
//   Frame scheduler and ROM-handshake controller for the RS485 UART transmitter.
//   It raises RQ once per frame period, steps the frame index `cycle` that the
//   transmitter uses to address the ROM, answers per-byte ROM requests with a
//   read strobe and a delayed ack, and flags transmitter timeouts and
//   frame-period overruns.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   en         in   scheduler enable; low forces idle and clears errors
//   full       in   transmitter frame-complete flag (edgeTx domain)
//   rqRom      in   transmitter ROM request (edgeTx domain)
//   RQ         out  transfer request to the transmitter (level)
//   ack        out  ROM data-valid acknowledge (level)
//   romRd      out  one-clk ROM read strobe
//   cycle      out  current frame index, 0..CYCLES-1
//   busy       out  main FSM not in IDLE
//   frameDone  out  one-clk pulse at the end of each completed frame
//   superDone  out  one-clk pulse when cycle wraps CYCLES-1 -> 0
//   err        out  sticky flags: [0] timeout, [1] overrun
//
// Main FSM
//   state      | meaning
//   S_IDLE     | waiting for the frame tick
//   S_ARM      | RQ raised, watchdog running
//   S_WAITFULL | RQ held, waiting for synchronized full or timeout
//   S_DROP     | RQ released, waiting for full to clear, then advance cycle
//   S_ABORT    | timed out, RQ released, waiting for full to clear
//
// ROM handshake FSM
//   state      | meaning
//   H_IDLE     | waiting for a qualified rqRom rise
//   H_LAT      | counting ROM read latency
//   H_ACK      | ack held until rqRom is released
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_frame_sched #(
  parameter logic [5:0]  CYCLES  = 6'd48,
  parameter logic [15:0] PERIOD  = 16'd1000,
  parameter logic [2:0]  ROM_LAT = 3'd2,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       full,
  input  logic       rqRom,
  output logic       RQ,
  output logic       ack,
  output logic       romRd,
  output logic [5:0] cycle,
  output logic       busy,
  output logic       frameDone,
  output logic       superDone,
  output logic [1:0] err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAITFULL, S_DROP, S_ABORT
  } main_state_t;

  typedef enum logic [1:0] {
    H_IDLE, H_LAT, H_ACK
  } hs_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic full_m, full_s;
  logic rq_m, rq_s, rq_s_d;
  logic rq_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_m <= 1'b0;
      full_s <= 1'b0;
      rq_m   <= 1'b0;
      rq_s   <= 1'b0;
      rq_s_d <= 1'b0;
    end else begin
      full_m <= full;
      full_s <= full_m;
      rq_m   <= rqRom;
      rq_s   <= rq_m;
      rq_s_d <= rq_s;
    end
  end

  assign rq_rise = rq_s & ~rq_s_d;

  // ---------------------------------------------------------------------------
  // Frame timer
  // ---------------------------------------------------------------------------
  logic [15:0] timer;
  logic        tick;

  assign tick = (timer == PERIOD - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= 16'd0;
    end else if (!en || tick) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  main_state_t state, state_n;
  logic [15:0] wdog, wdog_n;
  logic        rq_n, fd_n, sd_n;
  logic [5:0]  cycle_n;
  logic [1:0]  err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wdog      <= 16'd0;
      RQ        <= 1'b0;
      frameDone <= 1'b0;
      superDone <= 1'b0;
      cycle     <= 6'd0;
      err       <= 2'b00;
    end else begin
      state     <= state_n;
      wdog      <= wdog_n;
      RQ        <= rq_n;
      frameDone <= fd_n;
      superDone <= sd_n;
      cycle     <= cycle_n;
      err       <= err_n;
    end
  end

  // The watchdog is held at 0 in IDLE and counts from the clock RQ rises, so
  // the terminal compare in WAITFULL lands exactly TIMEOUT clks after RQ rise.
  always_comb begin
    state_n = state;
    wdog_n  = wdog;
    rq_n    = RQ;
    fd_n    = 1'b0;
    sd_n    = 1'b0;
    cycle_n = cycle;
    err_n   = err;

    case (state)
      S_IDLE: begin
        wdog_n = 16'd0;
        if (tick) begin
          state_n = S_ARM;
          rq_n    = 1'b1;
        end
      end
      S_ARM: begin
        wdog_n  = wdog + 16'd1;
        rq_n    = 1'b1;
        state_n = S_WAITFULL;
      end
      S_WAITFULL: begin
        wdog_n = wdog + 16'd1;
        // full wins over a coincident watchdog terminal count
        if (full_s) begin
          state_n = S_DROP;
          rq_n    = 1'b0;
        end else if (wdog == TIMEOUT - 16'd1) begin
          err_n[0] = 1'b1;
          state_n  = S_ABORT;
          rq_n     = 1'b0;
        end
      end
      S_DROP: begin
        rq_n = 1'b0;
        if (!full_s) begin
          fd_n    = 1'b1;
          state_n = S_IDLE;
          if (cycle == CYCLES - 6'd1) begin
            cycle_n = 6'd0;
            sd_n    = 1'b1;
          end else begin
            cycle_n = cycle + 6'd1;
          end
        end
      end
      S_ABORT: begin
        rq_n = 1'b0;
        if (!full_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        rq_n    = 1'b0;
      end
    endcase

    // A tick outside IDLE is dropped, not queued.
    if (tick && (state != S_IDLE)) begin
      err_n[1] = 1'b1;
    end

    if (!en) begin
      state_n = S_IDLE;
      wdog_n  = 16'd0;
      rq_n    = 1'b0;
      fd_n    = 1'b0;
      sd_n    = 1'b0;
      cycle_n = cycle;
      err_n   = 2'b00;
    end
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // ROM handshake FSM
  // ---------------------------------------------------------------------------
  hs_state_t hs, hs_n;
  logic [2:0] lat, lat_n;
  logic       ack_n, rd_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs    <= H_IDLE;
      lat   <= 3'd0;
      ack   <= 1'b0;
      romRd <= 1'b0;
    end else begin
      hs    <= hs_n;
      lat   <= lat_n;
      ack   <= ack_n;
      romRd <= rd_n;
    end
  end

  always_comb begin
    hs_n  = hs;
    lat_n = lat;
    ack_n = ack;
    rd_n  = 1'b0;

    case (hs)
      H_IDLE: begin
        // RQ is high only in ARM/WAITFULL, so this also rejects stray requests
        if (rq_rise && RQ) begin
          rd_n  = 1'b1;
          lat_n = 3'd0;
          hs_n  = H_LAT;
        end
      end
      H_LAT: begin
        lat_n = lat + 3'd1;
        if (lat == ROM_LAT - 3'd1) begin
          ack_n = 1'b1;
          hs_n  = H_ACK;
        end
      end
      H_ACK: begin
        if (!rq_s) begin
          ack_n = 1'b0;
          hs_n  = H_IDLE;
        end
      end
      default: begin
        hs_n  = H_IDLE;
        ack_n = 1'b0;
      end
    endcase

    if (!en) begin
      hs_n  = H_IDLE;
      lat_n = 3'd0;
      ack_n = 1'b0;
      rd_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
`timescale 1ns/1ps

module tb_uart_frame_sched;

  logic clk = 1'b0;
  logic rst_n;

  // instance A: PERIOD=100, CYCLES=3, ROM_LAT=2, TIMEOUT=50
  logic       a_en, a_full, a_req;
  logic       a_rq, a_ack, a_rd, a_busy, a_fd, a_sd;
  logic [5:0] a_cycle;
  logic [1:0] a_err;

  // instance B: PERIOD=20, CYCLES=3, ROM_LAT=1, TIMEOUT=4000 (overrun case)
  logic       b_en, b_full, b_req;
  logic       b_rq, b_ack, b_rd, b_busy, b_fd, b_sd;
  logic [5:0] b_cycle;
  logic [1:0] b_err;

  uart_frame_sched #(
    .CYCLES(6'd3), .PERIOD(16'd100), .ROM_LAT(3'd2), .TIMEOUT(16'd50)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .en(a_en), .full(a_full), .rqRom(a_req),
    .RQ(a_rq), .ack(a_ack), .romRd(a_rd), .cycle(a_cycle), .busy(a_busy),
    .frameDone(a_fd), .superDone(a_sd), .err(a_err)
  );

  uart_frame_sched #(
    .CYCLES(6'd3), .PERIOD(16'd20), .ROM_LAT(3'd1), .TIMEOUT(16'd4000)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .en(b_en), .full(b_full), .rqRom(b_req),
    .RQ(b_rq), .ack(b_ack), .romRd(b_rd), .cycle(b_cycle), .busy(b_busy),
    .frameDone(b_fd), .superDone(b_sd), .err(b_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int a_rd_cnt = 0, a_ack_cnt = 0, a_fd_cnt = 0, a_sd_cnt = 0, b_fd_cnt = 0;
  always @(negedge clk) begin
    if (a_rd  === 1'b1) a_rd_cnt  <= a_rd_cnt + 1;
    if (a_ack === 1'b1) a_ack_cnt <= a_ack_cnt + 1;
    if (a_fd  === 1'b1) a_fd_cnt  <= a_fd_cnt + 1;
    if (a_sd  === 1'b1) a_sd_cnt  <= a_sd_cnt + 1;
    if (b_fd  === 1'b1) b_fd_cnt  <= b_fd_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return a_rq;
      1:       return a_rd;
      2:       return a_ack;
      3:       return a_fd;
      4:       return b_rq;
      5:       return b_rd;
      6:       return b_ack;
      7:       return b_err[1];
      8:       return a_err[0];
      default: return 1'b0;
    endcase
  endfunction

  // counts negedges until the probed signal reaches val; returns max on expiry
  task automatic wait_for(input int sel, input logic val, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((probe(sel) !== val) && (n < max));
  endtask

  task automatic rom_req_a(input string tag);
    int n;
    a_req = 1'b1;
    wait_for(1, 1'b1, 20, n); check({tag, "_romrd_lat"}, n, 3);
    wait_for(2, 1'b1, 20, n); check({tag, "_ack_lat"}, n, 2);
    a_req = 1'b0;
    wait_for(2, 1'b0, 20, n); check({tag, "_ack_drop"}, n, 3);
  endtask

  task automatic finish_frame_a(input string tag, input logic [5:0] exp_cycle, input logic exp_sd);
    int n;
    a_full = 1'b1;
    wait_for(0, 1'b0, 20, n); check({tag, "_rq_drop"}, n, 3);
    a_full = 1'b0;
    wait_for(3, 1'b1, 20, n); check({tag, "_fd_lat"}, n, 3);
    check({tag, "_cycle"}, a_cycle, exp_cycle);
    check({tag, "_sd"}, a_sd, exp_sd);
    check({tag, "_busy"}, a_busy, 0);
    @(negedge clk);
    check({tag, "_pulse_end"}, {a_fd, a_sd}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    rst_n = 1'b0;
    a_en = 1'b0; a_full = 1'b0; a_req = 1'b0;
    b_en = 1'b0; b_full = 1'b0; b_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {a_rq, a_ack, a_rd, a_busy, a_fd, a_sd, a_err, a_cycle}, 0);

    // nominal frame
    rst_n = 1'b1; a_en = 1'b1;
    wait_for(0, 1'b1, 300, n); check("first_rq_lat", n, 100);
    check("nom_busy", a_busy, 1);
    for (int i = 0; i < 4; i++) rom_req_a($sformatf("nom%0d", i));
    repeat (2) @(negedge clk);
    check("nom_romrd_cnt", a_rd_cnt, 4);
    check("nom_ack_cnt", a_ack_cnt, 12);
    finish_frame_a("nom", 6'd1, 1'b0);
    check("nom_fd_cnt", a_fd_cnt, 1);

    // spurious request while RQ is low
    a_req = 1'b1;
    repeat (3) @(negedge clk);
    a_req = 1'b0;
    repeat (6) @(negedge clk);
    check("spur_romrd", a_rd_cnt, 4);
    check("spur_ack", a_ack_cnt, 12);

    // timeout
    wait_for(0, 1'b1, 200, n); check("to_rq", a_rq, 1);
    wait_for(8, 1'b1, 100, n); check("to_lat", n, 50);
    check("to_err", a_err, 2'b01);
    check("to_rq_low", a_rq, 0);
    repeat (3) @(negedge clk);
    check("to_cycle", a_cycle, 1);
    check("to_no_fd", a_fd_cnt, 1);
    check("to_idle", a_busy, 0);

    // enable low for one clk
    a_en = 1'b0;
    @(negedge clk);
    a_en = 1'b1;
    check("en_clr_err", a_err, 0);
    check("en_keep_cycle", a_cycle, 1);
    wait_for(0, 1'b1, 300, n); check("reen_rq_lat", n, 100);

    // wrap 1 -> 2 -> 0
    rom_req_a("f1");
    finish_frame_a("f1", 6'd2, 1'b0);
    wait_for(0, 1'b1, 200, n); check("f2_rq", a_rq, 1);
    finish_frame_a("f2", 6'd0, 1'b1);
    check("wrap_sd_cnt", a_sd_cnt, 1);
    check("wrap_fd_cnt", a_fd_cnt, 3);

    // set up a non-trivial state, then reset mid-handshake
    wait_for(0, 1'b1, 200, n); check("f3_rq", a_rq, 1);
    finish_frame_a("f3", 6'd1, 1'b0);
    wait_for(0, 1'b1, 200, n);
    wait_for(8, 1'b1, 100, n); check("to2_lat", n, 50);
    wait_for(0, 1'b1, 200, n);
    a_req = 1'b1;
    wait_for(2, 1'b1, 20, n);
    check("pre_rst_state", {a_rq, a_ack, a_err, a_cycle}, {2'b11, 2'b01, 6'd1});
    rst_n = 1'b0;
    #1;
    check("rst_mid", {a_rq, a_ack, a_busy, a_err, a_cycle}, 0);
    @(negedge clk);
    a_req = 1'b0;
    rst_n = 1'b1;
    wait_for(0, 1'b1, 300, n); check("rst_rq_lat", n, 100);
    a_en = 1'b0;

    // overrun on instance B
    @(negedge clk);
    b_en = 1'b1;
    wait_for(4, 1'b1, 100, n); check("b_first_rq", n, 20);
    t0 = cyc;
    check("b_busy", b_busy, 1);
    b_req = 1'b1;
    wait_for(5, 1'b1, 10, n); check("b_romrd_lat", n, 3);
    wait_for(6, 1'b1, 10, n); check("b_ack_lat1", n, 1);
    b_req = 1'b0;
    wait_for(6, 1'b0, 10, n); check("b_ack_drop", n, 3);
    wait_for(7, 1'b1, 40, n);
    check("b_ovr_time", cyc - t0, 20);
    check("b_err", b_err, 2'b10);
    check("b_rq_held", b_rq, 1);
    while (cyc - t0 < 40) @(negedge clk);
    check("b_rq_still", b_rq, 1);
    b_full = 1'b1;
    wait_for(4, 1'b0, 10, n); check("b_rq_drop", n, 3);
    b_full = 1'b0;
    wait_for(4, 1'b1, 100, n);
    check("b_next_rq_time", cyc - t0, 60);
    check("b_fd_cnt", b_fd_cnt, 1);
    check("b_cycle", b_cycle, 1);
    check("b_sd", b_sd, 0);
    check("b_err_end", b_err, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
